// File: rtl/alu_pipe_unit.sv
// rtl/alu_pipe_unit.sv - two-stage pipelined integer ALU with valid/ready handshakes
// S1 captures operands on accept; S2 holds the computed result and flags, driven straight to the outputs.
module alu_pipe_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow,
  output logic             Illegal
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             v1_q;

  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;
  logic             v2_q;

  logic             accept;
  logic             s2_load;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] arith;
  logic             is_sub;

  assign in_ready = !v1_q || !v2_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign s2_load  = v1_q && (!v2_q || out_ready);

  // add and sub share one adder: sub is A + ~B + 1
  assign is_sub = (op_q == OP_SUB);
  assign b_eff  = is_sub ? ~b_q : b_q;
  assign arith  = a_q + b_eff + {{(WIDTH-1){1'b0}}, is_sub};

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    ill_d = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d = arith;
        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (arith[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = arith;
        ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (arith[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_SLT: res_d = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: ill_d = 1'b1;
    endcase
    zero_d = (res_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      v1_q <= 1'b0;
    end else if (accept) begin
      a_q  <= SrcA;
      b_q  <= SrcB;
      op_q <= ALUControl;
      v1_q <= 1'b1;
    end else if (s2_load) begin
      v1_q <= 1'b0;
    end
  end

  // S2 contents stay put while stalled, so outputs are stable under backpressure
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      ill_q  <= 1'b0;
      v2_q   <= 1'b0;
    end else if (s2_load) begin
      res_q  <= res_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      ill_q  <= ill_d;
      v2_q   <= 1'b1;
    end else if (out_ready) begin
      v2_q   <= 1'b0;
    end
  end

  assign out_valid = v2_q;
  assign ALUResult = res_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign Illegal   = ill_q;

endmodule

// File: tb/tb_alu_pipe_unit.sv
// tb/tb_alu_pipe_unit.sv - randomized scoreboard bench for alu_pipe_unit
module tb_alu_pipe_unit;

  localparam int W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic [2:0]   ALUControl = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] ALUResult;
  logic         Zero, Overflow, Illegal;

  alu_pipe_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .Zero(Zero), .Overflow(Overflow), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic        il;
  } exp_t;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;
  bit   rand_bp = 1'b0;
  bit   hold_pending = 1'b0;
  logic [34:0] hold_val;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.res = '0; e.ov = 1'b0; e.il = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; e.res = s[31:0]; e.ov = (s > MAXS) || (s < MINS); end
      3'd1: begin s = sa - sb; e.res = s[31:0]; e.ov = (s > MAXS) || (s < MINS); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Handshakes decided at a falling edge complete on the following rising edge
  always @(negedge clk) begin
    if (!mon_en) begin
      sb_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {Illegal, Overflow, Zero, ALUResult}, hold_val);
      end
      check("in_ready", in_ready, (sb_q.size() < 2) || out_ready);
      if (out_valid && out_ready) begin
        check("out_has_pending", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("result", ALUResult, mon_e.res);
          check("zero", Zero, mon_e.z);
          check("overflow", Overflow, mon_e.ov);
          check("illegal", Illegal, mon_e.il);
        end
      end
      hold_pending = out_valid && !out_ready;
      hold_val = {Illegal, Overflow, Zero, ALUResult};
      if (in_valid && in_ready) sb_q.push_back(model(ALUControl, SrcA, SrcB));
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    in_valid = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      n++;
      @(negedge clk);
    end
    check("send_accepted", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", ALUResult, 0);
    check("rst_flags", {Zero, Overflow, Illegal}, 0);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    mon_en = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    in_valid = 1'b1; ALUControl = 3'd0; SrcA = 32'd5; SrcB = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_after_accept", out_valid, 0);
    @(posedge clk); #1;
    check("lat_out_valid", out_valid, 1);
    check("lat_result", ALUResult, 32'd12);
    check("lat_flags", {Zero, Overflow, Illegal}, 0);

    send(3'd1, 32'h1234, 32'h1234);
    send(3'd0, 32'h7FFF_FFFF, 32'd1);
    send(3'd5, 32'hFFFF_FFFF, 32'd1);
    send(3'd5, 32'd1, 32'hFFFF_FFFF);
    send(3'd2, 32'hF0F0, 32'h0FF0);
    send(3'd3, 32'hF0F0, 32'h0FF0);
    send(3'd7, 32'd9, 32'd9);
    send(3'd0, 32'd1, 32'd1);
    @(posedge clk); #1;
    check("add_after_illegal", {Illegal, ALUResult}, {1'b0, 32'd2});
    repeat (2) @(posedge clk);
    #1;

    out_ready = 1'b0;
    send(3'd0, 32'd1, 32'd0);
    send(3'd0, 32'd2, 32'd0);
    in_valid = 1'b1; ALUControl = 3'd0; SrcA = 32'd3; SrcB = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full_in_ready", in_ready, 0);
      @(posedge clk); #1;
      SrcA = $urandom; ALUControl = 3'($urandom_range(0, 7));
    end
    out_ready = 1'b1;
    send(3'd0, 32'd3, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("bp_drained", sb_q.size(), 0);

    out_ready = 1'b0;
    send(3'd0, 32'd10, 32'd0);
    send(3'd0, 32'd20, 32'd0);
    mon_en = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_result", ALUResult, 0);
    check("rst_mid_flags", {Zero, Overflow, Illegal}, 0);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale_after_rst", out_valid, 0);
    end
    @(posedge clk); #1;
    mon_en = 1'b1;

    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      send(3'($urandom_range(0, 7)), pick(), pick());
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("final_drain", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
